// File: rtl/nw_chunk_loader.sv
// rtl/nw_chunk_loader.sv - Needleman-Wunsch chunk grid feeder: string loader, grid kick-off, result capture
//
// Purpose: accepts LENGTH character pairs over a valid/ready handshake, packs
// them into the grid's parallel s1/s2 buses, pulses grid_reset once, waits
// (bounded by TIMEOUT) for the grid's bottom-right valid flag, then presents
// the captured score with done until out_ack.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - character pair handshake, data on c1/c2
//   s1, s2               - packed strings, beat i at [i*CWIDTH +: CWIDTH]
//   top_scores           - boundary row, slot i = i*INDEL
//   left_scores          - boundary column, slot j = (j+1)*INDEL
//   grid_reset           - one-cycle grid clear pulse
//   grid_valid/corner    - grid bottom-right valid flag and score
//   score, error, done   - captured result, timeout flag, result-available
//   out_ack              - consumer acknowledge of the result

module nw_chunk_loader #(
   parameter int LENGTH  = 10,
   parameter int CWIDTH  = 2,
   parameter int SWIDTH  = 16,
   parameter int INDEL   = -1,
   parameter int TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CWIDTH-1:0]            c1,
   input  logic [CWIDTH-1:0]            c2,
   output logic [LENGTH*CWIDTH-1:0]     s1,
   output logic [LENGTH*CWIDTH-1:0]     s2,
   output logic [(LENGTH+1)*SWIDTH-1:0] top_scores,
   output logic [LENGTH*SWIDTH-1:0]     left_scores,
   output logic                         grid_reset,
   input  logic                         grid_valid,
   input  logic [SWIDTH-1:0]            grid_corner,
   output logic [SWIDTH-1:0]            score,
   output logic                         error,
   output logic                         done,
   input  logic                         out_ack
);

   localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [LENGTH*CWIDTH-1:0]   s1_q, s1_d;
   logic [LENGTH*CWIDTH-1:0]   s2_q, s2_d;
   logic [SWIDTH-1:0]          score_q, score_d;
   logic                       error_q, error_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOAD;
         idx_q   <= '0;
         cnt_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         score_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         score_q <= score_d;
         error_q <= error_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      score_d = score_q;
      error_d = error_q;
      unique case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               // Slot decode by compare keeps the write index free of width games
               for (int k = 0; k < LENGTH; k++) begin
                  if (idx_q == IW'(k)) begin
                     s1_d[k*CWIDTH +: CWIDTH] = c1;
                     s2_d[k*CWIDTH +: CWIDTH] = c2;
                  end
               end
               idx_d = idx_q + IW'(1);
               if (idx_q == IW'(LENGTH-1)) begin
                  state_d = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            // grid_valid takes priority over a coincident timeout
            if (grid_valid) begin
               score_d = grid_corner;
               error_d = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               score_d = '0;
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ack) begin
               idx_d   = '0;
               s1_d    = '0;
               s2_d    = '0;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready   = (state_q == S_LOAD);
      grid_reset = (state_q == S_CLEAR);
      done       = (state_q == S_DONE);
      s1         = s1_q;
      s2         = s2_q;
      score      = score_q;
      error      = error_q;
   end

   // Boundary scores are elaboration-time constants: 32-bit signed products truncated to SWIDTH
   for (genvar i = 0; i <= LENGTH; i++) begin : g_top
      localparam logic [31:0] PROD = 32'(i * INDEL);
      assign top_scores[i*SWIDTH +: SWIDTH] = PROD[SWIDTH-1:0];
   end

   for (genvar j = 0; j < LENGTH; j++) begin : g_left
      localparam logic [31:0] PROD = 32'((j + 1) * INDEL);
      assign left_scores[j*SWIDTH +: SWIDTH] = PROD[SWIDTH-1:0];
   end

endmodule

// File: tb/tb_nw_chunk_loader.sv
// tb/tb_nw_chunk_loader.sv - directed self-checking bench for nw_chunk_loader

module tb_nw_chunk_loader;

   localparam int LENGTH  = 4;
   localparam int CWIDTH  = 2;
   localparam int SWIDTH  = 16;
   localparam int INDEL   = -1;
   localparam int TIMEOUT = 16;

   logic                         clk = 1'b0;
   logic                         reset;
   logic                         in_valid;
   logic                         in_ready;
   logic [CWIDTH-1:0]            c1, c2;
   logic [LENGTH*CWIDTH-1:0]     s1, s2;
   logic [(LENGTH+1)*SWIDTH-1:0] top_scores;
   logic [LENGTH*SWIDTH-1:0]     left_scores;
   logic                         grid_reset;
   logic                         grid_valid;
   logic [SWIDTH-1:0]            grid_corner;
   logic [SWIDTH-1:0]            score;
   logic                         error;
   logic                         done;
   logic                         out_ack;

   int tests_run    = 0;
   int tests_failed = 0;

   nw_chunk_loader #(
      .LENGTH (LENGTH),
      .CWIDTH (CWIDTH),
      .SWIDTH (SWIDTH),
      .INDEL  (INDEL),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .c1         (c1),
      .c2         (c2),
      .s1         (s1),
      .s2         (s2),
      .top_scores (top_scores),
      .left_scores(left_scores),
      .grid_reset (grid_reset),
      .grid_valid (grid_valid),
      .grid_corner(grid_corner),
      .score      (score),
      .error      (error),
      .done       (done),
      .out_ack    (out_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; observation point is 1 time unit after the rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] a, input logic [1:0] b);
      in_valid = 1'b1;
      c1 = a;
      c2 = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; c1 = '0; c2 = '0;
      grid_valid = 1'b0; grid_corner = '0; out_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // Reset values and boundary constants
      check("rst_in_ready", in_ready, 1);
      check("rst_done", done, 0);
      check("rst_grid_reset", grid_reset, 0);
      check("rst_s1", s1, 0);
      check("rst_s2", s2, 0);
      check("rst_score", score, 0);
      check("rst_error", error, 0);
      check("top_scores", top_scores, 80'hFFFC_FFFD_FFFE_FFFF_0000);
      check("left_scores", left_scores, 64'hFFFC_FFFD_FFFE_FFFF);

      // grid_valid during LOAD is ignored
      grid_valid = 1'b1; grid_corner = 16'h1234;
      tick();
      grid_valid = 1'b0;
      check("gv_in_load_done", done, 0);
      check("gv_in_load_ready", in_ready, 1);

      // Load with a gap between beats 2 and 3
      beat(2'd0, 2'd3);
      check("ld_gr_b1", grid_reset, 0);
      beat(2'd1, 2'd2);
      check("ld_gr_b2", grid_reset, 0);
      tick();
      check("ld_gap_ready", in_ready, 1);
      beat(2'd2, 2'd1);
      check("ld_gr_b3", grid_reset, 0);
      beat(2'd3, 2'd0);
      check("ld_gr_clear", grid_reset, 1);
      check("ld_ready_clear", in_ready, 0);
      check("ld_s1", s1, 8'hE4);
      check("ld_s2", s2, 8'h1B);
      tick();  // RUN cycle 0
      check("run0_gr", grid_reset, 0);
      check("run0_ready", in_ready, 0);

      // Normal completion: grid_valid in RUN cycle 6
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("run_wait_done", done, 0);
      end
      grid_valid = 1'b1; grid_corner = 16'hFFFE;
      tick();
      grid_valid = 1'b0;
      check("nc_done", done, 1);
      check("nc_score", score, 16'hFFFE);
      check("nc_error", error, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("nc_hold_done", done, 1);
         check("nc_hold_score", score, 16'hFFFE);
         check("nc_hold_ready", in_ready, 0);
      end
      // Ack with a beat presented in the same cycle: the beat must not be taken
      out_ack = 1'b1; in_valid = 1'b1; c1 = 2'd3; c2 = 2'd3;
      tick();
      out_ack = 1'b0; in_valid = 1'b0;
      check("ack_ready", in_ready, 1);
      check("ack_done", done, 0);
      check("ack_s1", s1, 0);
      check("ack_score_hold", score, 16'hFFFE);

      // Timeout load; a stale ack-cycle beat would shift idx and fire grid_reset early
      beat(2'd1, 2'd2);
      beat(2'd1, 2'd2);
      beat(2'd1, 2'd2);
      check("to_gr_b3", grid_reset, 0);
      beat(2'd1, 2'd2);
      check("to_gr_b4", grid_reset, 1);
      check("to_s1", s1, 8'h55);
      check("to_s2", s2, 8'hAA);
      // Hold in_valid with other data through CLEAR/RUN/DONE
      in_valid = 1'b1; c1 = 2'd3; c2 = 2'd3;
      tick();  // RUN entry
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         check("to_done_edge", done, (k == TIMEOUT) ? 1 : 0);
      end
      check("to_error", error, 1);
      check("to_score", score, 0);
      check("to_hold_s1", s1, 8'h55);
      check("to_hold_s2", s2, 8'hAA);
      tick();
      check("to_hold_done", done, 1);
      in_valid = 1'b0;
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check("to_ack_ready", in_ready, 1);

      // grid_valid coinciding with the final timeout cycle wins
      for (int k = 0; k < 4; k++) beat(2'd2, 2'd0);
      check("co_gr", grid_reset, 1);
      tick();  // RUN cycle 0
      for (int k = 1; k < TIMEOUT; k++) tick();  // RUN cycle TIMEOUT-1
      check("co_pre_done", done, 0);
      grid_valid = 1'b1; grid_corner = 16'h0007;
      tick();
      grid_valid = 1'b0;
      check("co_done", done, 1);
      check("co_error", error, 0);
      check("co_score", score, 16'h0007);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;

      // Reset mid-load discards partial strings
      beat(2'd3, 2'd3);
      beat(2'd3, 2'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("ml_s1", s1, 0);
      check("ml_s2", s2, 0);
      check("ml_gr", grid_reset, 0);
      check("ml_ready", in_ready, 1);
      check("ml_score", score, 0);
      beat(2'd2, 2'd1);
      check("ml_gr_b1", grid_reset, 0);
      beat(2'd0, 2'd3);
      check("ml_gr_b2", grid_reset, 0);
      beat(2'd1, 2'd0);
      check("ml_gr_b3", grid_reset, 0);
      beat(2'd3, 2'd2);
      check("ml_gr_b4", grid_reset, 1);
      check("ml_s1_new", s1, 8'hD2);
      check("ml_s2_new", s2, 8'h8D);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/nw_chunk_loader.md
# nw_chunk_loader

Upstream feeder for the Needleman-Wunsch chunk grid. It accepts the two DNA strings one character pair per beat over a valid/ready handshake and packs them into the grid's parallel `s1`/`s2` buses. It also drives the constant first-chunk boundary scores, pulses the grid's reset, and waits for the grid's valid flag. It then captures the bottom-right score and presents it with `done` until the consumer acknowledges it.

## Interface

Parameters:

- `LENGTH`, 10: characters per string, which is also the grid edge length.
- `CWIDTH`, 2: bits per character.
- `SWIDTH`, 16: bits per score, two's complement.
- `INDEL`, -1: gap weight used to build the boundary scores.
- `TIMEOUT`, 64: maximum RUN cycles to wait for `grid_valid`; must be ≥ 2.

Ports:

- `clk`, input, 1: single clock; everything is sampled on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: character pair present on `c1`/`c2`.
- `in_ready`, output, 1: loader accepts a pair this cycle.
- `c1`, input, CWIDTH: character of string 1.
- `c2`, input, CWIDTH: character of string 2.
- `s1`, output, LENGTH*CWIDTH: packed string 1; beat i lands at `[i*CWIDTH +: CWIDTH]`.
- `s2`, output, LENGTH*CWIDTH: packed string 2, same packing.
- `top_scores`, output, (LENGTH+1)*SWIDTH: slot i equals i*INDEL, for i = 0..LENGTH.
- `left_scores`, output, LENGTH*SWIDTH: slot j equals (j+1)*INDEL, for j = 0..LENGTH-1.
- `grid_reset`, output, 1: one-cycle pulse that clears the grid's valid state.
- `grid_valid`, input, 1: grid bottom-right cell valid.
- `grid_corner`, input, SWIDTH: grid bottom-right score.
- `score`, output, SWIDTH: captured result.
- `error`, output, 1: the result was produced by timeout.
- `done`, output, 1: result available; held until acknowledged.
- `out_ack`, input, 1: consumer acknowledges the result.

## Operation

- **States:** LOAD, CLEAR, RUN, DONE. `reset` forces LOAD.
- **LOAD**
  - `in_ready` = 1.
  - An accepted beat (`in_valid && in_ready`) writes `c1`/`c2` into slot `idx` of `s1`/`s2`, then increments `idx`.
  - The beat accepted at `idx == LENGTH-1` moves the FSM to CLEAR.
  - `idx` width is `$clog2(LENGTH)`, minimum 1.
- **CLEAR**
  - `grid_reset` = 1 for exactly this one cycle.
  - Clears the RUN counter; next state is RUN.
- **RUN**
  - Counter increments every cycle.
  - If `grid_valid` = 1: `score` <= `grid_corner`, `error` <= 0, go to DONE.
  - Else, when the counter reaches `TIMEOUT-1`: `score` <= 0, `error` <= 1, go to DONE.
  - If `grid_valid` and the timeout coincide, `grid_valid` wins.
- **DONE**
  - `done` = 1.
  - On `out_ack`: clear `idx`, `s1`, `s2`, and `done`, then go to LOAD.
  - `score` and `error` hold until the next capture.
- **Input filtering:**
  - `grid_valid` is ignored outside RUN.
  - `out_ack` is ignored outside DONE.
  - `in_valid` is ignored outside LOAD.
- **Stability:** `s1`/`s2` are stable from CLEAR through DONE.
- **Boundary scores:**
  - Combinational constants derived from the parameters.
  - Each product is computed in 32-bit signed arithmetic and truncated to SWIDTH.
  - They do not depend on state.

## Timing

- **Reset values:** `in_ready`=1, `s1`=0, `s2`=0, `grid_reset`=0, `score`=0, `error`=0, `done`=0, `idx`=0, RUN counter=0, state=LOAD.
- **Reset mid-operation:** from any state, the FSM returns to LOAD next cycle with all reset values. Partial strings are discarded and `grid_reset` is not pulsed.
- **Load latency:** exactly LENGTH accepted beats. `in_valid` gaps stall without penalty.
- **Load to grid reset:** `grid_reset` is high in the cycle immediately after the final beat is accepted.
- **Grid wait:** RUN begins the cycle after CLEAR.
  - `grid_valid` sampled high in RUN cycle n (n = 0 is the first RUN cycle) gives `done` = 1 in cycle n+1.
  - With no `grid_valid`, `done` rises TIMEOUT cycles after RUN entry.
- **Acknowledge:** `out_ack` in DONE gives `in_ready` = 1 on the next cycle. A beat presented with `in_valid` during the ack cycle is not accepted.
- **Minimum iteration:** LENGTH + 3 cycles (load, CLEAR, RUN, DONE with immediate ack).

## Test plan

All scenarios use LENGTH=4, SWIDTH=16, TIMEOUT=16.

- **Reset:** assert `reset` → `in_ready`=1, `done`=0, `grid_reset`=0, `s1`=`s2`=0, `score`=0, `error`=0. Also check `top_scores` = {FFFC, FFFD, FFFE, FFFF, 0000} (slot 4 down to slot 0) and `left_scores` = {FFFC, FFFD, FFFE, FFFF}.
- **Load:** send pairs (c1,c2) = (0,3), (1,2), (2,1), (3,0) with one idle cycle between beats 2 and 3 → `s1`=8'hE4, `s2`=8'h1B. `grid_reset` is high for exactly the one cycle after beat 4, and `in_ready`=0 from that cycle on.
- **Normal completion:** raise `grid_valid` in RUN cycle 6 with `grid_corner`=16'hFFFE → next cycle `done`=1, `score`=-2, `error`=0. These hold for 5 cycles without `out_ack`; `out_ack` then gives `in_ready`=1 and `s1`=0.
- **Timeout:** never assert `grid_valid` → `done`=1 exactly 16 cycles after RUN entry, `error`=1, `score`=0. Also: `grid_valid` coinciding with the final timeout cycle gives `error`=0.
- **Reset mid-load:** assert `reset` after 2 accepted beats → `s1`=0. The next 4 beats alone form the strings, and `grid_reset` fires only after the 4th of them.
- **Ignored inputs:**
  - `in_valid` held high through CLEAR/RUN/DONE changes neither `s1`/`s2` nor `idx`.
  - `grid_valid` pulsed during LOAD does not produce `done`.
  - `in_valid` together with `out_ack` is not accepted that cycle.
